// File: rtl/axi_lite_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_mem_model
// Brief    : AXI4-Lite memory slave: in-order read queue, SLVERR on unmapped
//            addresses, console/pass MMIO ports. Define AXI_MEM_STALL_EN for
//            xorshift64 pseudo-random backpressure on every channel.
// Revision : 1.0
// ============================================================================

module axi_lite_mem_model #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    MEM_BYTES    = 65536,
  parameter int                    RD_DEPTH     = 4,
  parameter logic [ADDR_WIDTH-1:0] CONSOLE_ADDR = ADDR_WIDTH'(32'h1000_0000),
  parameter logic [ADDR_WIDTH-1:0] PASS_ADDR    = ADDR_WIDTH'(32'h2000_0000),
  parameter logic [63:0]           LFSR_SEED    = 64'd88172645463325252,
  parameter logic [4:0]            STALL_MASK   = 5'b11111
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_axi_awvalid,
  output logic                    mem_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   mem_axi_awaddr,
  input  logic                    mem_axi_wvalid,
  output logic                    mem_axi_wready,
  input  logic [DATA_WIDTH-1:0]   mem_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_axi_wstrb,
  output logic                    mem_axi_bvalid,
  input  logic                    mem_axi_bready,
  output logic [1:0]              mem_axi_bresp,
  input  logic                    mem_axi_arvalid,
  output logic                    mem_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   mem_axi_araddr,
  output logic                    mem_axi_rvalid,
  input  logic                    mem_axi_rready,
  output logic [DATA_WIDTH-1:0]   mem_axi_rdata,
  output logic [1:0]              mem_axi_rresp,
  output logic                    console_valid,
  output logic [7:0]              console_data,
  output logic                    tests_passed
);

  localparam int                    STRB_W     = DATA_WIDTH / 8;
  localparam int                    OFS        = $clog2(STRB_W);
  localparam int                    MAW        = $clog2(MEM_BYTES);
  localparam int                    IDX_W      = (MAW > OFS) ? (MAW - OFS) : 1;
  localparam int                    NWORDS     = MEM_BYTES / STRB_W;
  localparam int                    QP_W       = $clog2(RD_DEPTH);
  localparam logic [QP_W:0]         QP_ONE     = 1;
  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT  = ADDR_WIDTH'(MEM_BYTES);
  localparam logic [31:0]           PASS_MAGIC = 32'd123456789;
  localparam logic [1:0]            RESP_OKAY  = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] memory [NWORDS];

  logic stall_ar, stall_aw, stall_w, stall_r, stall_b;

`ifdef AXI_MEM_STALL_EN
  logic [63:0] lfsr;
  logic [63:0] lfsr_x1, lfsr_x2, lfsr_next;

  always_comb begin
    lfsr_x1   = lfsr ^ (lfsr << 13);
    lfsr_x2   = lfsr_x1 ^ (lfsr_x1 >> 7);
    lfsr_next = lfsr_x2 ^ (lfsr_x2 << 17);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next;
  end

  assign {stall_b, stall_r, stall_w, stall_aw, stall_ar} = lfsr[4:0] & STALL_MASK;
`else
  logic unused_cfg;
  assign unused_cfg = ^{LFSR_SEED, STALL_MASK};
  assign {stall_b, stall_r, stall_w, stall_aw, stall_ar} = 5'b00000;
`endif

  // Read-address queue: pointers carry one wrap bit to tell full from empty.
  logic [IDX_W-1:0] q_idx [RD_DEPTH];
  logic             q_oob [RD_DEPTH];
  logic [QP_W:0]    q_wr, q_rd;
  logic             q_full, q_empty, ar_fire, r_pop;

  assign q_empty = (q_wr == q_rd);
  assign q_full  = (q_wr[QP_W] != q_rd[QP_W]) && (q_wr[QP_W-1:0] == q_rd[QP_W-1:0]);

  assign mem_axi_arready = !reset && !q_full && !stall_ar;
  assign ar_fire = mem_axi_arvalid && mem_axi_arready;
  assign r_pop   = !q_empty && (!mem_axi_rvalid || mem_axi_rready) && !stall_r;

  always_ff @(posedge clk) begin
    if (ar_fire) begin
      q_idx[q_wr[QP_W-1:0]] <= IDX_W'(mem_axi_araddr >> OFS);
      q_oob[q_wr[QP_W-1:0]] <= (mem_axi_araddr >= MEM_LIMIT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_wr           <= '0;
      q_rd           <= '0;
      mem_axi_rvalid <= 1'b0;
      mem_axi_rdata  <= '0;
      mem_axi_rresp  <= RESP_OKAY;
    end else begin
      if (ar_fire) q_wr <= q_wr + QP_ONE;
      if (r_pop) begin
        q_rd           <= q_rd + QP_ONE;
        mem_axi_rvalid <= 1'b1;
        if (q_oob[q_rd[QP_W-1:0]]) begin
          mem_axi_rdata <= '0;
          mem_axi_rresp <= RESP_SLVERR;
        end else begin
          mem_axi_rdata <= memory[q_idx[q_rd[QP_W-1:0]]];
          mem_axi_rresp <= RESP_OKAY;
        end
      end else if (mem_axi_rready) begin
        mem_axi_rvalid <= 1'b0;
      end
    end
  end

  // Write path: independent one-entry AW and W holding registers.
  logic                  aw_held, w_held, commit;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  wr_in_mem, wr_console, wr_pass;
  logic [IDX_W-1:0]      wr_idx;

  assign mem_axi_awready = !reset && !aw_held && !stall_aw;
  assign mem_axi_wready  = !reset && !w_held && !stall_w;
  assign commit     = aw_held && w_held && (!mem_axi_bvalid || mem_axi_bready) && !stall_b;
  assign wr_in_mem  = (aw_addr < MEM_LIMIT);
  assign wr_console = (aw_addr == CONSOLE_ADDR);
  assign wr_pass    = (aw_addr == PASS_ADDR);
  assign wr_idx     = IDX_W'(aw_addr >> OFS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      aw_addr        <= '0;
      w_data         <= '0;
      w_strb         <= '0;
      mem_axi_bvalid <= 1'b0;
      mem_axi_bresp  <= RESP_OKAY;
      console_valid  <= 1'b0;
      console_data   <= 8'h00;
      tests_passed   <= 1'b0;
    end else begin
      console_valid <= 1'b0;
      if (mem_axi_awvalid && mem_axi_awready) begin
        aw_held <= 1'b1;
        aw_addr <= mem_axi_awaddr;
      end
      if (mem_axi_wvalid && mem_axi_wready) begin
        w_held <= 1'b1;
        w_data <= mem_axi_wdata;
        w_strb <= mem_axi_wstrb;
      end
      if (commit) begin
        aw_held        <= 1'b0;
        w_held         <= 1'b0;
        mem_axi_bvalid <= 1'b1;
        mem_axi_bresp  <= (wr_in_mem || wr_console || wr_pass) ? RESP_OKAY : RESP_SLVERR;
        if (wr_console && w_strb[0]) begin
          console_valid <= 1'b1;
          console_data  <= w_data[7:0];
        end
        if (wr_pass && (w_data[31:0] == PASS_MAGIC)) tests_passed <= 1'b1;
      end else if (mem_axi_bready) begin
        mem_axi_bvalid <= 1'b0;
      end
    end
  end

  // Storage is deliberately unreset so preloaded images survive reset.
  always_ff @(posedge clk) begin
    if (commit && wr_in_mem) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb[b]) memory[wr_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/axi_lite_mem_model.md
# axi_lite_mem_model

Parametrised AXI4-Lite memory slave used as the simulation and emulation memory behind the `picorv32_axi` core. Supports a configurable data width and memory size, queues multiple outstanding reads, and returns SLVERR for unmapped accesses instead of halting the simulation. Exposes the console and test-pass MMIO locations as ports so benches and FPGA wrappers observe them without system tasks. Optional pseudo-random backpressure is available on every channel.

## Interface
- DATA_WIDTH, 32: bus data width; 32 or 64.
- ADDR_WIDTH, 32: bus address width.
- MEM_BYTES, 65536: memory size in bytes; power of two, at least DATA_WIDTH/8.
- RD_DEPTH, 4: read-address queue depth; power of two, at least 2.
- CONSOLE_ADDR, 32'h1000_0000: console MMIO address.
- PASS_ADDR, 32'h2000_0000: test-pass MMIO address.
- LFSR_SEED, 64'd88172645463325252: xorshift64 seed.
- STALL_MASK, 5'b11111: per-channel stall enable, bits {b, r, w, aw, ar}.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_axi_awvalid / mem_axi_awready  in/out  1  write-address handshake.
- mem_axi_awaddr  in  ADDR_WIDTH  write address.
- mem_axi_wvalid / mem_axi_wready  in/out  1  write-data handshake.
- mem_axi_wdata  in  DATA_WIDTH  write data.
- mem_axi_wstrb  in  DATA_WIDTH/8  byte strobes.
- mem_axi_bvalid / mem_axi_bready  out/in  1  write-response handshake.
- mem_axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- mem_axi_arvalid / mem_axi_arready  in/out  1  read-address handshake.
- mem_axi_araddr  in  ADDR_WIDTH  read address.
- mem_axi_rvalid / mem_axi_rready  out/in  1  read-data handshake.
- mem_axi_rdata  out  DATA_WIDTH  read data.
- mem_axi_rresp  out  2  read response.
- console_valid  out  1  one-cycle pulse per accepted console write.
- console_data  out  8  console byte.
- tests_passed  out  1  sticky pass flag.

## Operation
- Storage is the array `memory`, with MEM_BYTES/(DATA_WIDTH/8) words. Word index is `addr[log2(MEM_BYTES)-1 : log2(DATA_WIDTH/8)]`. Low address bits are ignored.
- Memory contents are not reset. Benches preload the array hierarchically.
- Reset values: all readies, valids, `rdata`, `rresp`, `bresp`, `console_valid`, `console_data` and `tests_passed` are 0. The read queue is empty, the write holding registers are empty, and the LFSR equals LFSR_SEED.

Read path:
- `arready` = !queue_full && !stall_ar.
- An AR handshake pushes {word index, oob}, where oob = (araddr >= MEM_BYTES).
- The R output register loads when the queue is not empty, (!rvalid || rready), and !stall_r. The load pops one entry and sets rvalid = 1.
  - In-range entry: rdata = memory word, rresp = OKAY.
  - Out-of-range entry: rdata = 0, rresp = SLVERR.
- If `rready` is high, rvalid clears and nothing is loaded, rvalid falls to 0.
- Responses are returned in order. Throughput is one per cycle.
- While the queue is full, `arready` = 0, even in a cycle where a pop occurs.

Write path:
- AW and W are captured independently into one-entry holding registers.
  - `awready` = !aw_held && !stall_aw.
  - `wready` = !w_held && !stall_w.
  - Both may handshake in the same cycle.
- Commit happens when aw_held && w_held && (!bvalid || bready) && !stall_b. At commit:
  - addr < MEM_BYTES: write the strobed bytes; bresp = OKAY.
  - addr == CONSOLE_ADDR: if wstrb[0] is set, console_valid = 1 for one cycle and console_data = wdata[7:0]; bresp = OKAY.
  - addr == PASS_ADDR: if wdata[31:0] == 123456789, set tests_passed. It stays set until reset. bresp = OKAY.
  - Any other address: no side effect; bresp = SLVERR.
  - After commit, bvalid = 1 and both holding registers clear.
- If a read pop and a write commit to the same word fall on the same edge, the read returns the old data. Any later pop sees the new data.

## Timing
- Read: AR handshake in cycle k gives rvalid in cycle k+2 at the earliest.
- Write: the later of the AW and W handshakes in cycle k gives bvalid in cycle k+2 at the earliest.
- A response stays stable while its valid is high and its ready is low.
- Reset asserted mid-operation drops all queued reads, held writes and pending responses. Outputs return to their reset values asynchronously.

## Configuration
- `AXI_MEM_STALL_EN` defined:
  - A 64-bit xorshift state advances every cycle as s ^= s<<13; s ^= s>>7; s ^= s<<17.
  - stall_{ar,aw,w,r,b} = s[0..4] & STALL_MASK[0..4].
  - A stall never drops a valid that is already asserted; it only delays new ready, valid or commit.
- Not defined: no LFSR is built, all stalls are tied to 0, and LFSR_SEED and STALL_MASK are unused.

## Test plan
- Preload memory[3] = 32'hDEADBEEF, then read addr 0xC with rready = 1: rvalid in cycle k+2, rdata = 32'hDEADBEEF, rresp = 0.
- Issue 6 back-to-back reads with RD_DEPTH = 4 and rready held low for 10 cycles: arready drops after 4 AR handshakes plus 1 held in R; releasing rready returns 6 in-order beats, one per cycle.
- Write 32'h11223344 with wstrb 4'b0101 to 0x10 over an initial word of 0: memory[4] = 32'h00220044, bresp = 0. Also send W two cycles before AW: bvalid appears 2 cycles after the AW handshake.
- Write 0x41 to CONSOLE_ADDR: one-cycle console_valid with console_data = 8'h41. Write 123456789 to PASS_ADDR: tests_passed = 1, sticky. Writing 5 to PASS_ADDR leaves the flag unchanged.
- Read 0x0001_0000 and write 0x3000_0000: rresp = 2'b10, rdata = 0, bresp = 2'b10, no memory change.
- With `AXI_MEM_STALL_EN` defined, run 1000 random reads and writes against a reference model: data and response order match. Assert reset mid-burst: all valids are 0 immediately, and memory contents are retained.
